// File: rtl/bf2_exmem.sv
// bf2_exmem: EX/MEM pipeline register with valid/ready handshake.
// Holds the 84-bit EX-stage payload (WB/M control, ALU result and zero flag,
// store data, destination register, branch target) for the MEM stage.
// Build option BF2_SKID_EN: adds a skid entry (capacity 2) so inReady_BF2
// comes straight from a flop. Without it the stage holds one entry and
// inReady_BF2 is combinational from outReady_BF2.
// Flush drops every held entry. The stall counter is not cleared by flush;
// only reset clears it.
module bf2_exmem (
    input  logic        clk_BF2,
    input  logic        rst_BF2,
    input  logic [2:0]  wbIn_BF2,
    input  logic [2:0]  mIn_BF2,
    input  logic [31:0] aluRes_BF2,
    input  logic        zero_BF2,
    input  logic [31:0] storeData_BF2,
    input  logic [4:0]  wrReg_BF2,
    input  logic [7:0]  brAddr_BF2,
    input  logic        inValid_BF2,
    output logic        inReady_BF2,
    output logic        outValid_BF2,
    input  logic        outReady_BF2,
    input  logic        flush_BF2,
    output logic [2:0]  wbBF2,
    output logic [2:0]  mBF2,
    output logic [31:0] aluResBF2,
    output logic        zeroBF2,
    output logic [31:0] storeDataBF2,
    output logic [4:0]  wrRegBF2,
    output logic [7:0]  brAddrBF2,
    output logic [15:0] stallCntBF2
);

    // m bits: [0] MemRead, [1] MemWrite, [2] Branch
    typedef struct packed {
        logic [2:0]  wb;
        logic [2:0]  m;
        logic [31:0] alu;
        logic        zero;
        logic [31:0] sd;
        logic [4:0]  wr;
        logic [7:0]  br;
    } pay_t;

    pay_t        in_pl;
    pay_t        main_q;
    logic        main_vld;
    logic        accept;
    logic        issue;
    logic [15:0] stall_q;

    assign in_pl  = {wbIn_BF2, mIn_BF2, aluRes_BF2, zero_BF2,
                     storeData_BF2, wrReg_BF2, brAddr_BF2};
    assign accept = inValid_BF2 & inReady_BF2;
    assign issue  = main_vld & outReady_BF2;

`ifdef BF2_SKID_EN
    pay_t skid_q;
    logic skid_vld;

    // skid_vld is a flop, so upstream ready never sees outReady_BF2
    assign inReady_BF2 = ~skid_vld;

    // Main/skid update: refill main from skid first, otherwise from input;
    // park the input in skid when main is held.
    always_ff @(posedge clk_BF2) begin
        if (rst_BF2) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (flush_BF2) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || issue) begin
            if (skid_vld) begin
                // inReady_BF2 is low here, so no accept can collide
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                main_vld <= accept;
                if (accept)
                    main_q <= in_pl;
            end
        end else if (accept) begin
            skid_q   <= in_pl;
            skid_vld <= 1'b1;
        end
    end

    // skid only ever fills behind a held main entry
    a_skid_behind_main: assert property (@(posedge clk_BF2) disable iff (rst_BF2)
        skid_vld |-> main_vld);
`else
    // single entry: ready when empty or draining this cycle
    assign inReady_BF2 = ~main_vld | outReady_BF2;

    // Main update: load on accept, otherwise drop the entry once issued.
    always_ff @(posedge clk_BF2) begin
        if (rst_BF2) begin
            main_vld <= 1'b0;
            main_q   <= '0;
        end else if (flush_BF2) begin
            main_vld <= 1'b0;
        end else if (!main_vld || issue) begin
            main_vld <= accept;
            if (accept)
                main_q <= in_pl;
        end
    end
`endif

    // Saturating count of back-pressured cycles; flush does not touch it.
    always_ff @(posedge clk_BF2) begin
        if (rst_BF2)
            stall_q <= '0;
        else if (main_vld && !outReady_BF2 && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    // control is gated to zero on a bubble so MEM never sees a stray write;
    // data fields hold whatever the last entry left behind
    assign outValid_BF2 = main_vld;
    assign wbBF2        = main_vld ? main_q.wb : 3'b000;
    assign mBF2         = main_vld ? main_q.m  : 3'b000;
    assign aluResBF2    = main_q.alu;
    assign zeroBF2      = main_q.zero;
    assign storeDataBF2 = main_q.sd;
    assign wrRegBF2     = main_q.wr;
    assign brAddrBF2    = main_q.br;
    assign stallCntBF2  = stall_q;

    // held payload must not move while the consumer stalls
    a_hold_stable: assert property (@(posedge clk_BF2) disable iff (rst_BF2 || flush_BF2)
        (main_vld && !outReady_BF2) |=> (main_vld && $stable(main_q)));

endmodule

// File: doc/bf2_exmem.md
BF2_EXMEM -- requirements
Module: bf2_exmem

Interface
REQ-001 SHALL expose clk_BF2  input  1  single clock; all state updates on posedge.
REQ-002 SHALL expose rst_BF2  input  1  reset, synchronous, active-high.
REQ-003 SHALL expose wbIn_BF2  input  3  WB control bits from the ID/EX stage.
REQ-004 SHALL expose mIn_BF2  input  3  M control bits: [0] MemRead, [1] MemWrite, [2] Branch.
REQ-005 SHALL expose aluRes_BF2  input  32  ALU result; zero_BF2  input  1  ALU zero flag.
REQ-006 SHALL expose storeData_BF2  input  32  rt register value (store data).
REQ-007 SHALL expose wrReg_BF2  input  5  destination register from the RegDst mux.
REQ-008 SHALL expose brAddr_BF2  input  8  branch target address.
REQ-009 SHALL expose inValid_BF2  input  1, and inReady_BF2  output  1  upstream handshake.
REQ-010 SHALL expose outValid_BF2  output  1, and outReady_BF2  input  1  downstream handshake.
REQ-011 SHALL expose flush_BF2  input  1  discards all held entries.
REQ-012 SHALL expose outputs wbBF2 3, mBF2 3, aluResBF2 32, zeroBF2 1, storeDataBF2 32, wrRegBF2 5, brAddrBF2 8: registered payload for MEM.
REQ-013 SHALL expose stallCntBF2  output  16  count of back-pressured cycles.

Function
REQ-014 Payload SHALL be the 84-bit concatenation of wb, m, aluRes, zero, storeData, wrReg and brAddr, carried unmodified.
REQ-015 Accept SHALL occur when inValid_BF2 && inReady_BF2 at a posedge; issue SHALL occur when outValid_BF2 && outReady_BF2.
REQ-016 Storage SHALL be a main register (drives outputs) plus a skid register; capacity 2 entries.
REQ-017 inReady_BF2 SHALL be registered and equal !skidValid (no combinational path from outReady_BF2).
REQ-018 Empty main, or main issuing with empty skid: an accept SHALL load main; latency input->output 1 cycle.
REQ-019 Main held (not issuing) while accepting: the entry SHALL go to skid; inReady_BF2 SHALL drop next cycle.
REQ-020 Main issuing with skid full: skid SHALL move to main in that cycle, inReady_BF2 SHALL rise next cycle.
REQ-021 Order SHALL be FIFO; no entry lost or duplicated under any outReady_BF2 pattern.
REQ-022 Payload outputs SHALL hold stable while outValid_BF2=1 and outReady_BF2=0.
REQ-023 When outValid_BF2=0, wbBF2 and mBF2 SHALL read 3'b000 (bubble: no spurious memory or register write); data outputs may hold stale values.
REQ-024 flush_BF2=1 SHALL clear main and skid valid bits at that edge, override any same-cycle accept, and give inReady_BF2=1 next cycle.
REQ-025 stallCntBF2 SHALL increment each cycle with outValid_BF2=1 and outReady_BF2=0, saturate at 16'hFFFF, and not be cleared by flush.

Reset
REQ-026 rst_BF2=1 at a posedge SHALL clear main/skid valid bits, all payload outputs and stallCntBF2 to 0, and set inReady_BF2=1.
REQ-027 Reset SHALL override flush and any handshake in the same cycle; held entries mid-operation are discarded.

Configuration
REQ-028 Macro BF2_SKID_EN defined: skid register present per REQ-016..REQ-020.
REQ-029 BF2_SKID_EN undefined: capacity 1; no skid register; inReady_BF2 = !outValid_BF2 || outReady_BF2 (combinational); all other REQs hold.

Verification
REQ-030 Reset then inValid=1, aluRes=32'h0000_00A5, mIn=3'b010, outReady=1 -> next cycle outValid=1, aluResBF2=32'h0000_00A5, mBF2=3'b010.
REQ-031 outReady=0, accept A=32'h11 then B=32'h22 -> main=A, skid=B, inReady=0, stallCnt counts; outReady=1 -> A then B issued in order, inReady=1.
REQ-032 Two entries held, flush=1 with inValid=1 same cycle -> next cycle outValid=0, wbBF2=mBF2=0, inReady=1, new entry not captured.
REQ-033 outReady=0 for 70000 cycles with valid entry -> stallCntBF2=16'hFFFF and holds; payload stable throughout.
REQ-034 rst=1 asserted with skid full and flush=1 -> all outputs 0, inReady=1, stallCntBF2=0.
REQ-035 Build without BF2_SKID_EN: outValid=1, outReady=0 -> inReady=0 same cycle; outReady=1 -> inReady=1 same cycle, back-to-back throughput 1 per cycle.
